// File: rtl/ring_display_scanner_pkg.sv
// Shared types and constants for the ring display scanner.
package rds_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   localparam int NUM_DIGITS = 4;

   // Active-high segment encodings, seg[0]=a .. seg[6]=g
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // One-hot scan phases from the upstream ring counter
   localparam logic [3:0] PH_D0 = 4'b0001;
   localparam logic [3:0] PH_D1 = 4'b0010;
   localparam logic [3:0] PH_D2 = 4'b0100;
   localparam logic [3:0] PH_D3 = 4'b1000;

endpackage

// File: rtl/ring_display_scanner_if.sv
// Handshake and display bus of the ring display scanner.
interface ring_display_scanner_if;
   logic [3:0]  phase;
   logic        load;
   logic [15:0] data;
   logic        ready;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        err;

   modport master (output phase, output load, output data,
                   input ready, input seg, input an, input err);
   modport slave  (input phase, input load, input data,
                   output ready, output seg, output an, output err);
endinterface

// File: rtl/ring_display_scanner_bcd_to_seg7.sv
// BCD digit to active-high 7-segment pattern; 10..15 render as a dash.
module bcd_to_seg7
   import rds_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // pure lookup, out-of-range codes fall through to the dash
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/ring_display_scanner.sv
// Four-digit multiplexed display scanner with double-buffered frame load,
// frame-boundary swap and sticky phase-fault detection.
module ring_display_scanner
   import rds_pkg::*;
#(
   parameter bit LZ_BLANK       = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)(
   input  logic clk,
   input  logic rst,
   ring_display_scanner_if.slave bus
);

   state_e      state_q, state_d;
   logic        ready_q, ready_d;      // 1 = shadow buffer empty
   logic [15:0] shadow_q, shadow_d;
   logic [15:0] active_q, active_d;
   logic [3:0]  prev_phase_q, prev_phase_d;
   logic [6:0]  seg_q, seg_d;
   logic [3:0]  an_q, an_d;

   logic [NUM_DIGITS-1:0][6:0] dig_seg;
   logic [NUM_DIGITS-1:0]      blank;
   logic [6:0]                 seg_act;
   logic [3:0]                 an_act;
   logic                       boundary;

   // decode every digit of the frame that will be active after this edge
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
      bcd_to_seg7 u_dec (.bcd(active_d[4*i +: 4]), .seg(dig_seg[i]));
   end

   // leading-zero blanking works on the active frame; digit 0 always shows
   always_comb begin
      blank = '0;
      if (LZ_BLANK) begin
         blank[3] = (active_d[15:12] == 4'd0);
         blank[2] = blank[3] && (active_d[11:8] == 4'd0);
         blank[1] = blank[2] && (active_d[7:4] == 4'd0);
      end
   end

   // state, shadow/active buffers and load handshake
   always_comb begin
      state_d      = state_q;
      ready_d      = ready_q;
      shadow_d     = shadow_q;
      active_d     = active_q;
      prev_phase_d = prev_phase_q;
      boundary     = (bus.phase == PH_D0) && (prev_phase_q == PH_D3);
      if (state_q != ST_FAULT) begin
         if (!$onehot(bus.phase)) begin
            state_d = ST_FAULT;
            ready_d = 1'b0;
         end else begin
            prev_phase_d = bus.phase;
            // swap needs a full shadow and load needs an empty one, so
            // they never collide and a frame is never torn
            if (boundary && !ready_q) begin
               active_d = shadow_q;
               ready_d  = 1'b1;
               state_d  = ST_RUN;
            end else if (bus.load && ready_q) begin
               shadow_d = bus.data;
               ready_d  = 1'b0;
            end
         end
      end
   end

   // next display word; polarity only applied on the way into the flops
   always_comb begin
      seg_act = SEG_BLANK;
      an_act  = '0;
      if (state_d == ST_RUN) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.phase[i]) begin
               an_act[i] = 1'b1;
               seg_act   = blank[i] ? SEG_BLANK : dig_seg[i];
            end
         end
      end
      seg_d = seg_act ^ {7{SEG_ACTIVE_LOW}};
      an_d  = an_act ^ {4{SEG_ACTIVE_LOW}};
   end

   // all state registers, async active-low clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         ready_q      <= 1'b1;
         shadow_q     <= 16'h0000;
         active_q     <= 16'h0000;
         prev_phase_q <= PH_D3;
         seg_q        <= {7{SEG_ACTIVE_LOW}};
         an_q         <= {4{SEG_ACTIVE_LOW}};
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         prev_phase_q <= prev_phase_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.err   = (state_q == ST_FAULT);
   assign bus.seg   = seg_q;
   assign bus.an    = an_q;

endmodule

// File: tb/tb_ring_display_scanner.sv
// Randomized bench: two scanner instances (blanking/active-low on, and both
// off) share one stimulus stream and are compared every cycle to a model.
module tb_ring_display_scanner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ring_display_scanner_if bus0 ();
   ring_display_scanner_if bus1 ();

   assign bus1.phase = bus0.phase;
   assign bus1.load  = bus0.load;
   assign bus1.data  = bus0.data;

   ring_display_scanner #(.LZ_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0));
   ring_display_scanner #(.LZ_BLANK(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1));

   int errs   = 0;
   int checks = 0;

   // segment pictures for 0..9, bit0=a .. bit6=g
   logic [6:0] pic [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                            7'b1111111, 7'b1101111};

   // behavioural model
   bit          m_fault, m_run, m_full, m_on;
   logic [15:0] m_shadow, m_active;
   logic [3:0]  m_prev;
   int          m_pos;
   logic [3:0]  ring;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_fault = 0; m_run = 0; m_full = 0; m_on = 0;
      m_shadow = 16'h0; m_active = 16'h0; m_prev = 4'b1000; m_pos = 0;
   endtask

   task automatic model_step(input logic [3:0] ph, input logic ld, input logic [15:0] d);
      if (m_fault) begin
         m_on = 0;
      end else if ($countones(ph) != 1) begin
         m_fault = 1;
         m_on = 0;
      end else begin
         if (ph == 4'b0001 && m_prev == 4'b1000 && m_full) begin
            m_active = m_shadow;
            m_full = 0;
            m_run = 1;
         end else if (ld && !m_full) begin
            m_shadow = d;
            m_full = 1;
         end
         m_prev = ph;
         m_on = m_run;
         for (int i = 0; i < 4; i++) if (ph[i]) m_pos = i;
      end
   endtask

   function automatic logic [6:0] exp_seg(input bit lz, input bit al);
      logic [6:0]  raw;
      logic [15:0] upper;
      int          v;
      raw = 7'h00;
      if (m_on) begin
         upper = m_active >> (4 * m_pos);
         v = int'(upper & 16'hF);
         if (lz && m_pos > 0 && upper == 16'h0) raw = 7'h00;
         else if (v > 9) raw = 7'b1000000;
         else raw = pic[v];
      end
      return al ? ~raw : raw;
   endfunction

   function automatic logic [3:0] exp_an(input bit al);
      logic [3:0] raw;
      raw = m_on ? 4'(1 << m_pos) : 4'h0;
      return al ? ~raw : raw;
   endfunction

   task automatic check_all();
      chk("seg0",   {25'd0, bus0.seg},   {25'd0, exp_seg(1, 1)});
      chk("an0",    {28'd0, bus0.an},    {28'd0, exp_an(1)});
      chk("ready0", {31'd0, bus0.ready}, {31'd0, !m_full && !m_fault});
      chk("err0",   {31'd0, bus0.err},   {31'd0, m_fault});
      chk("seg1",   {25'd0, bus1.seg},   {25'd0, exp_seg(0, 0)});
      chk("an1",    {28'd0, bus1.an},    {28'd0, exp_an(0)});
      chk("ready1", {31'd0, bus1.ready}, {31'd0, !m_full && !m_fault});
      chk("err1",   {31'd0, bus1.err},   {31'd0, m_fault});
   endtask

   task automatic cyc(input logic [3:0] ph, input logic ld, input logic [15:0] d);
      bus0.phase = ph; bus0.load = ld; bus0.data = d;
      @(posedge clk);
      model_step(ph, ld, d);
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [15:0] rand_frame();
      int k;
      logic [15:0] v;
      k = $urandom_range(0, 4);
      v = 16'($urandom);
      return v & 16'(32'hFFFF >> (4 * k));
   endfunction

   task automatic run_ring(input int n, input int load_pct, input bit hold_en);
      for (int i = 0; i < n; i++) begin
         cyc(ring, ($urandom_range(0, 99) < load_pct), rand_frame());
         if (!(hold_en && $urandom_range(0, 3) == 0)) ring = {ring[2:0], ring[3]};
      end
   endtask

   task automatic load_frame(input logic [15:0] d, input int n);
      cyc(ring, 1'b1, d);
      ring = {ring[2:0], ring[3]};
      run_ring(n, 0, 0);
   endtask

   // async reset entered between edges, released on a falling edge
   task automatic do_reset();
      #3 rst = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rst = 1'b1;
      ring = 4'b0001;
   endtask

   function automatic logic [3:0] rand_bad_phase();
      logic [3:0] p;
      p = 4'($urandom);
      while ($countones(p) == 1) p = 4'($urandom);
      return p;
   endfunction

   initial begin
      bus0.phase = 4'b0001; bus0.load = 1'b0; bus0.data = 16'h0;
      ring = 4'b0001;
      model_reset();
      #1 rst = 1'b0;
      #1 check_all();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // idle scan, then 1234 with an ignored 9999 right behind it
      run_ring(5, 0, 0);
      cyc(ring, 1'b1, 16'h1234); ring = {ring[2:0], ring[3]};
      cyc(ring, 1'b1, 16'h9999); ring = {ring[2:0], ring[3]};
      run_ring(16, 0, 0);

      load_frame(16'h0070, 12);
      load_frame(16'h00AF, 12);
      load_frame(16'h0000, 12);
      load_frame(16'hF00F, 12);
      run_ring(400, 30, 1);

      // reset with a frame waiting in the shadow
      if (!m_full) begin
         cyc(ring, 1'b1, 16'h5678); ring = {ring[2:0], ring[3]};
      end
      bus0.phase = ring; bus0.load = 1'b0;
      @(posedge clk);
      model_step(ring, 1'b0, bus0.data);
      #2 rst = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rst = 1'b1;
      ring = 4'b0001;
      run_ring(8, 0, 0);
      run_ring(100, 30, 1);

      // two hot bits, then loads and scanning while faulted
      cyc(4'b0011, 1'b0, 16'h0);
      run_ring(10, 50, 0);
      do_reset();

      // invalid phase on the very first edge after release
      cyc(4'b0000, 1'b1, 16'h4321);
      run_ring(5, 50, 0);
      do_reset();

      for (int r = 0; r < 4; r++) begin
         run_ring($urandom_range(50, 150), 30, 1);
         cyc(rand_bad_phase(), 1'b0, 16'h0);
         run_ring(5, 30, 0);
         do_reset();
      end
      run_ring(60, 40, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
